// File: rtl/btn_conditioner.sv
// Per-button 2-FF sync + counter debounce -> registered level and 1-cycle press/release pulses; DB_CYC+2 cycle latency.
// Define BTN_AUTOREPEAT_EN to add held-button press repeats (REPEAT_DELAY_MS first, then every REPEAT_RATE_MS).
`timescale 1ns/1ps
module btn_conditioner #(
  parameter int N_BTN           = 5,
  parameter int CLK_HZ          = 40_000_000,
  parameter int DEBOUNCE_US     = 10_000,
  parameter int REPEAT_DELAY_MS = 400,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int DB_CYC = CLK_HZ / 1_000_000 * DEBOUNCE_US;
  localparam int DB_W   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

  if (DB_CYC < 2) begin : g_bad_db_cfg
    $error("btn_conditioner: debounce must span at least 2 clock cycles");
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RD_CYC = CLK_HZ / 1_000 * REPEAT_DELAY_MS;
  localparam int RR_CYC = CLK_HZ / 1_000 * REPEAT_RATE_MS;
  localparam int RC_MAX = (RD_CYC > RR_CYC) ? RD_CYC : RR_CYC;
  localparam int RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;
  localparam logic [RC_W-1:0] RD_LAST = RC_W'(RD_CYC - 1);
  localparam logic [RC_W-1:0] RR_LAST = RC_W'(RR_CYC - 1);

  if (RD_CYC < 2 || RR_CYC < 2) begin : g_bad_rep_cfg
    $error("btn_conditioner: repeat delay/rate must span at least 2 clock cycles");
  end
`else
  // Repeat settings have no effect in this build.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY_MS > 0) ^ (REPEAT_RATE_MS > 0);
`endif

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [DB_W-1:0] cnt;
    logic            level_q;
    logic            press_q;
    logic            release_q;
    logic            accept;
    logic            repeat_hit;

    // A level change is taken once s2 has disagreed with the level for DB_CYC cycles in a row.
    assign accept = (sync2[i] != level_q) && (cnt == DB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        if ((sync2[i] == level_q) || accept) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (accept) begin
          level_q <= sync2[i];
        end
        press_q   <= (accept && sync2[i]) || repeat_hit;
        release_q <= accept && !sync2[i];
      end
    end

`ifdef BTN_AUTOREPEAT_EN
    logic [RC_W-1:0] rc;
    logic            rate_phase;

    // An accepted release outranks a repeat falling due on the same cycle.
    assign repeat_hit = level_q && !accept && (rc == (rate_phase ? RR_LAST : RD_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rc         <= '0;
        rate_phase <= 1'b0;
      end else if (!level_q || accept) begin
        rc         <= '0;
        rate_phase <= 1'b0;
      end else if (repeat_hit) begin
        rc         <= '0;
        rate_phase <= 1'b1;
      end else begin
        rc <= rc + 1'b1;
      end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random toggling, all checked every cycle
// against a history-window reference model. Honours BTN_AUTOREPEAT_EN the same way as the design.
`timescale 1ns/1ps
module tb_btn_conditioner;
  localparam int N_BTN  = 5;
  localparam int DB_CYC = 8;
  localparam int RD_CYC = 2000;
  localparam int RR_CYC = 1000;

  logic             clk;
  logic             rst_n;
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  btn_conditioner #(
    .N_BTN(N_BTN), .CLK_HZ(1_000_000), .DEBOUNCE_US(8),
    .REPEAT_DELAY_MS(2), .REPEAT_RATE_MS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw samples per edge; a channel flips when the DB_CYC values the
  // debouncer has seen (two edges of sync delay) all oppose the current level.
  logic [N_BTN-1:0] exp_level, exp_press, exp_release;
  logic [N_BTN-1:0] samples[$];
  int unsigned      held[N_BTN];

  function automatic bit opposite_run(int ch, logic lvl);
    int sz;
    sz = samples.size();
    if (sz < DB_CYC + 2) return 1'b0;
    for (int k = sz - 2 - DB_CYC; k <= sz - 3; k++)
      if (samples[k][ch] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples.delete();
      exp_level   <= '0;
      exp_press   <= '0;
      exp_release <= '0;
      for (int ch = 0; ch < N_BTN; ch++) held[ch] = 0;
    end else begin
      logic [N_BTN-1:0] lvl, prs, rel;
      samples.push_back(btn_in);
      if (samples.size() > 4 * DB_CYC) void'(samples.pop_front());
      lvl = exp_level;
      prs = '0;
      rel = '0;
      for (int ch = 0; ch < N_BTN; ch++) begin
        if (opposite_run(ch, exp_level[ch])) begin
          lvl[ch]  = ~exp_level[ch];
          prs[ch]  = lvl[ch];
          rel[ch]  = ~lvl[ch];
          held[ch] = 0;
        end else if (exp_level[ch]) begin
          held[ch]++;
`ifdef BTN_AUTOREPEAT_EN
          if (held[ch] >= RD_CYC && (held[ch] - RD_CYC) % RR_CYC == 0) prs[ch] = 1'b1;
`endif
        end
      end
      exp_level   <= lvl;
      exp_press   <= prs;
      exp_release <= rel;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pcnt[N_BTN];
  int rcnt[N_BTN];
  int press_t[$];

`ifdef BTN_AUTOREPEAT_EN
  int exp_off[4] = '{0, 2000, 3000, 4000};
`else
  int exp_off[1] = '{0};
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check("model_level",   32'(btn_level),   32'(exp_level));
    check("model_press",   32'(btn_press),   32'(exp_press));
    check("model_release", 32'(btn_release), 32'(exp_release));
    for (int ch = 0; ch < N_BTN; ch++) begin
      pcnt[ch] += int'(btn_press[ch]);
      rcnt[ch] += int'(btn_release[ch]);
    end
    if (btn_press[4]) press_t.push_back(cyc);
  endtask

  task automatic clear_counts();
    for (int ch = 0; ch < N_BTN; ch++) begin
      pcnt[ch] = 0;
      rcnt[ch] = 0;
    end
  endtask

  task automatic settle();
    btn_in = '0;
    repeat (30) step();
  endtask

  // Bounded wait: n == 200 on timeout, which fails any latency check.
  task automatic wait_for(input logic [N_BTN-1:0] mask, input logic [N_BTN-1:0] val, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (((btn_level & mask) != val) && n < 200);
  endtask

  initial begin
    int n;
    int p0;
    rst_n  = 1'b0;
    btn_in = '1;
    clear_counts();

    // 1: reset with all buttons held, then release
    repeat (3) step();
    check("t1_reset_level",   32'(btn_level),   32'h0);
    check("t1_reset_press",   32'(btn_press),   32'h0);
    check("t1_reset_release", 32'(btn_release), 32'h0);
    rst_n = 1'b1;
    wait_for(5'h1F, 5'h1F, n);
    check("t1_latency", 32'(n), 32'd10);
    check("t1_press_all", 32'(btn_press), 32'h1F);
    step();
    check("t1_press_gone", 32'(btn_press), 32'h0);

    // 2: clean press and release on channel 1
    settle();
    btn_in[1] = 1'b1;
    wait_for(5'h02, 5'h02, n);
    check("t2_press_latency", 32'(n), 32'd10);
    check("t2_press_hi", 32'(btn_press[1]), 32'd1);
    step();
    check("t2_press_lo", 32'(btn_press[1]), 32'd0);
    repeat (89) step();
    btn_in[1] = 1'b0;
    wait_for(5'h02, 5'h00, n);
    check("t2_release_latency", 32'(n), 32'd10);
    check("t2_release_hi", 32'(btn_release[1]), 32'd1);

    // 3: bounce on channel 2 then steady high
    settle();
    clear_counts();
    for (int p = 0; p < 8; p++) begin
      btn_in[2] = 1'b1;
      repeat (3) step();
      btn_in[2] = 1'b0;
      repeat (2) step();
    end
    btn_in[2] = 1'b1;
    wait_for(5'h04, 5'h04, n);
    check("t3_latency", 32'(n), 32'd10);
    repeat (20) step();
    check("t3_one_press", 32'(pcnt[2]), 32'd1);
    check("t3_no_release", 32'(rcnt[2]), 32'd0);

    // 4: glitch rejection at DB_CYC-1, acceptance at DB_CYC
    settle();
    clear_counts();
    btn_in[0] = 1'b1;
    repeat (7) step();
    btn_in[0] = 1'b0;
    repeat (30) step();
    check("t4_glitch7_press", 32'(pcnt[0]), 32'd0);
    check("t4_glitch7_release", 32'(rcnt[0]), 32'd0);
    btn_in[0] = 1'b1;
    repeat (8) step();
    btn_in[0] = 1'b0;
    repeat (30) step();
    check("t4_pulse8_press", 32'(pcnt[0]), 32'd1);
    check("t4_pulse8_release", 32'(rcnt[0]), 32'd1);

    // 5: reset in the middle of a debounce count
    settle();
    btn_in[3] = 1'b1;
    repeat (6) step();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_level_in_reset", 32'(btn_level[3]), 32'd0);
    end
    rst_n = 1'b1;
    wait_for(5'h08, 5'h08, n);
    check("t5_latency_after_reset", 32'(n), 32'd10);
    check("t5_press_hi", 32'(btn_press[3]), 32'd1);

    // 6: long hold on channel 4 (auto-repeat when enabled)
    settle();
    btn_in[4] = 1'b1;
    press_t.delete();
    wait_for(5'h10, 5'h10, n);
    check("t6_latency", 32'(n), 32'd10);
    p0 = cyc;
    repeat (4990) step();
    btn_in[4] = 1'b0;
    repeat (30) step();
    check("t6_press_count", 32'(press_t.size()), 32'($size(exp_off)));
    for (int i = 0; i < $size(exp_off) && i < press_t.size(); i++)
      check("t6_press_offset", 32'(press_t[i] - p0), 32'(exp_off[i]));

    // 7: random toggling on all channels, model-checked each cycle
    settle();
    for (int t = 0; t < 3000; t++) begin
      for (int ch = 0; ch < N_BTN; ch++)
        if ($urandom_range(11) == 0) btn_in[ch] = ~btn_in[ch];
      step();
    end
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
